// File: rtl/rbm_train_sched.sv
// rbm_train_sched
// Sequences the RBM datapath through contrastive-divergence training
// (per sample: LOAD, POS, k_dim x (NEG_V, NEG_H); UPDATE after each batch)
// or a single inference pass (LOAD, POS per sample). It issues one command
// at a time and waits for the completion pulse before issuing the next.
//
// Ports
//   ACLK, ARESET        clock, synchronous active-high reset
//   start               run request, acted on at its rising edge in IDLE
//   soft_rst            synchronous abort to IDLE, clears flags and counters
//   mode_train          1 = CD-k training, 0 = inference (latched at start)
//   batch_size, n_batches, epochs, k_dim   run configuration
//   cmd_valid/cmd_op/cmd_ready             command handshake to the datapath
//   op_done             completion pulse for the accepted command
//   accum_clr           one-cycle accumulator clear before each training batch
//   busy, done, err, err_code              status (done/err sticky)
//   batch_done, epoch_done                 one-cycle progress pulses
//   sample_idx, batch_idx, epoch_idx, cd_step   current position, zero-based
module rbm_train_sched #(
    parameter int TIMEOUT = 65535
) (
    input  logic        ACLK,
    input  logic        ARESET,
    input  logic        start,
    input  logic        soft_rst,
    input  logic        mode_train,
    input  logic [15:0] batch_size,
    input  logic [15:0] n_batches,
    input  logic [15:0] epochs,
    input  logic [7:0]  k_dim,
    output logic        cmd_valid,
    output logic [2:0]  cmd_op,
    input  logic        cmd_ready,
    input  logic        op_done,
    output logic        accum_clr,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code,
    output logic        batch_done,
    output logic        epoch_done,
    output logic [15:0] sample_idx,
    output logic [15:0] batch_idx,
    output logic [15:0] epoch_idx,
    output logic [7:0]  cd_step
);

    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [2:0] OP_LOAD   = 3'd0;
    localparam logic [2:0] OP_POS    = 3'd1;
    localparam logic [2:0] OP_NEG_V  = 3'd2;
    localparam logic [2:0] OP_NEG_H  = 3'd3;
    localparam logic [2:0] OP_UPDATE = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_CLR, S_ISSUE, S_WAIT, S_DONE, S_ERR
    } state_t;

    state_t        state, state_d;
    logic          start_q;
    logic          mode_q, mode_d;
    logic [2:0]    op_q, op_d;
    logic [TW-1:0] tcnt, tcnt_d;
    logic [15:0]   samp_q, samp_d, batch_q, batch_d, epoch_q, epoch_d;
    logic [7:0]    cd_q, cd_d;
    logic          done_q, done_d, err_q, err_d;
    logic [1:0]    code_q, code_d;
    logic          bdone_q, bdone_d, edone_q, edone_d;

    logic start_edge, bad_cfg;
    logic last_cd, last_samp, last_batch, last_epoch;

    assign start_edge = start & ~start_q;
    assign bad_cfg    = (batch_size == 16'd0) || (n_batches == 16'd0) ||
                        (mode_q && ((epochs == 16'd0) || (k_dim == 8'd0)));
    assign last_cd    = (cd_q    == k_dim      - 8'd1);
    assign last_samp  = (samp_q  == batch_size - 16'd1);
    assign last_batch = (batch_q == n_batches  - 16'd1);
    assign last_epoch = (epoch_q == epochs     - 16'd1);

    always_comb begin
        state_d = state;
        mode_d  = mode_q;
        op_d    = op_q;
        tcnt_d  = tcnt;
        samp_d  = samp_q;
        batch_d = batch_q;
        epoch_d = epoch_q;
        cd_d    = cd_q;
        done_d  = done_q;
        err_d   = err_q;
        code_d  = code_q;
        bdone_d = 1'b0;
        edone_d = 1'b0;

        case (state)
            S_IDLE: begin
                if (start_edge) begin
                    state_d = S_CHECK;
                    mode_d  = mode_train;
                    samp_d  = '0;
                    batch_d = '0;
                    epoch_d = '0;
                    cd_d    = '0;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    code_d  = 2'd0;
                end
            end
            S_CHECK: begin
                op_d = OP_LOAD;
                if (bad_cfg) begin
                    state_d = S_ERR;
                    err_d   = 1'b1;
                    code_d  = 2'd1;
                end else if (mode_q) begin
                    state_d = S_CLR;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_CLR: begin
                state_d = S_ISSUE;
                op_d    = OP_LOAD;
            end
            S_ISSUE: begin
                if (cmd_ready) begin
                    state_d = S_WAIT;
                    tcnt_d  = '0;
                end
            end
            S_WAIT: begin
                if (op_done) begin
                    state_d = S_ISSUE;
                    case (op_q)
                        OP_LOAD: op_d = OP_POS;
                        OP_POS: begin
                            if (mode_q) begin
                                op_d = OP_NEG_V;
                            end else begin
                                // Inference: POS closes the sample.
                                op_d = OP_LOAD;
                                if (last_samp) begin
                                    samp_d  = '0;
                                    bdone_d = 1'b1;
                                    if (last_batch) begin
                                        batch_d = '0;
                                        epoch_d = epoch_q + 16'd1;
                                        edone_d = 1'b1;
                                        done_d  = 1'b1;
                                        state_d = S_DONE;
                                    end else begin
                                        batch_d = batch_q + 16'd1;
                                    end
                                end else begin
                                    samp_d = samp_q + 16'd1;
                                end
                            end
                        end
                        OP_NEG_V: op_d = OP_NEG_H;
                        OP_NEG_H: begin
                            // NEG_H closes one CD step; the last step closes the sample.
                            if (last_cd) begin
                                cd_d = '0;
                                if (last_samp) begin
                                    samp_d = '0;
                                    op_d   = OP_UPDATE;
                                end else begin
                                    samp_d = samp_q + 16'd1;
                                    op_d   = OP_LOAD;
                                end
                            end else begin
                                cd_d = cd_q + 8'd1;
                                op_d = OP_NEG_V;
                            end
                        end
                        OP_UPDATE: begin
                            bdone_d = 1'b1;
                            op_d    = OP_LOAD;
                            state_d = S_CLR;
                            if (last_batch) begin
                                batch_d = '0;
                                epoch_d = epoch_q + 16'd1;
                                edone_d = 1'b1;
                                if (last_epoch) begin
                                    done_d  = 1'b1;
                                    state_d = S_DONE;
                                end
                            end else begin
                                batch_d = batch_q + 16'd1;
                            end
                        end
                        default: state_d = S_ISSUE;
                    endcase
                end else if (tcnt == TW'(TIMEOUT - 1)) begin
                    // This is the TIMEOUT-th WAIT cycle without a completion.
                    state_d = S_ERR;
                    err_d   = 1'b1;
                    code_d  = 2'd2;
                end else begin
                    tcnt_d = tcnt + TW'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Abort overrides every transition, including a pending handshake.
        if (soft_rst) begin
            state_d = S_IDLE;
            tcnt_d  = '0;
            samp_d  = '0;
            batch_d = '0;
            epoch_d = '0;
            cd_d    = '0;
            done_d  = 1'b0;
            err_d   = 1'b0;
            code_d  = 2'd0;
            bdone_d = 1'b0;
            edone_d = 1'b0;
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state   <= S_IDLE;
            start_q <= 1'b0;
            mode_q  <= 1'b0;
            op_q    <= OP_LOAD;
            tcnt    <= '0;
            samp_q  <= '0;
            batch_q <= '0;
            epoch_q <= '0;
            cd_q    <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= 2'd0;
            bdone_q <= 1'b0;
            edone_q <= 1'b0;
        end else begin
            state   <= state_d;
            start_q <= start;
            mode_q  <= mode_d;
            op_q    <= op_d;
            tcnt    <= tcnt_d;
            samp_q  <= samp_d;
            batch_q <= batch_d;
            epoch_q <= epoch_d;
            cd_q    <= cd_d;
            done_q  <= done_d;
            err_q   <= err_d;
            code_q  <= code_d;
            bdone_q <= bdone_d;
            edone_q <= edone_d;
        end
    end

    assign cmd_valid  = (state == S_ISSUE);
    assign cmd_op     = op_q;
    assign accum_clr  = (state == S_CLR);
    assign busy       = (state == S_CLR) || (state == S_ISSUE) || (state == S_WAIT);
    assign done       = done_q;
    assign err        = err_q;
    assign err_code   = code_q;
    assign batch_done = bdone_q;
    assign epoch_done = edone_q;
    assign sample_idx = samp_q;
    assign batch_idx  = batch_q;
    assign epoch_idx  = epoch_q;
    assign cd_step    = cd_q;

endmodule

// File: doc/rbm_train_sched.md
# rbm_train_sched

Sequencer that drives the RBM datapath through contrastive-divergence training, or a single inference pass, from the register-file configuration. It sits between the AXI-Lite control registers and the RBM compute/DMA engines. It issues one operation at a time over a valid/ready command port and waits for a completion pulse before issuing the next. It produces the busy/done/err/batch/epoch status that the register file reads back and turns into interrupts.

## Interface
- TIMEOUT, 65535: max cycles in WAIT before a timeout error
- ACLK  in  1  clock
- ARESET  in  1  synchronous active-high reset
- start  in  1  run request; acts on rising edge only
- soft_rst  in  1  synchronous abort to IDLE, clears sticky flags
- mode_train  in  1  1 = CD-k training, 0 = inference; sampled at start
- batch_size  in  16  samples per batch
- n_batches  in  16  batches per epoch
- epochs  in  16  epoch count (train only)
- k_dim  in  8  CD steps per sample (train only)
- cmd_valid  out  1  command valid
- cmd_op  out  3  0 LOAD, 1 POS, 2 NEG_V, 3 NEG_H, 4 UPDATE
- cmd_ready  in  1  datapath accepts command
- op_done  in  1  one-cycle completion pulse for the accepted command
- accum_clr  out  1  one-cycle pulse clearing the pos/neg accumulators
- busy  out  1  high from CLR/ISSUE until DONE/ERR
- done  out  1  sticky; cleared by next accepted start, soft_rst, or ARESET
- err  out  1  sticky; same clear rules as done
- err_code  out  2  1 = bad config, 2 = timeout, 0 = none
- batch_done, epoch_done  out  1  one-cycle pulses
- sample_idx, batch_idx, epoch_idx  out  16  current position, zero-based
- cd_step  out  8  current CD step, zero-based

## Operation
- States: IDLE, CHECK, CLR, ISSUE, WAIT, DONE, ERR.
- **IDLE:** a start rising edge (start high, previous-cycle start low) latches mode_train and moves to CHECK. A start edge in any other state is ignored.
- **CHECK:** goes to ERR with err_code=1 if batch_size==0 or n_batches==0, or, in train mode, if epochs==0 or k_dim==0. Otherwise goes to CLR in train mode and to ISSUE with op LOAD in inference.
- **CLR:** asserts accum_clr for one cycle, then goes to ISSUE with op LOAD.
- **ISSUE:** holds cmd_valid=1 with cmd_op stable until cmd_ready. On the handshake cycle, moves to WAIT and resets the timeout counter.
- **WAIT:** cmd_valid=0. On op_done, selects the next op and returns to ISSUE.
- Train-mode op sequence, per sample: LOAD, POS, then k_dim pairs of (NEG_V, NEG_H).
- After the last sample of a batch, train mode issues UPDATE. When UPDATE completes:
  - batch_done pulses.
  - If the batch was the last of the epoch, epoch_done also pulses.
  - If the epoch was the last, go to DONE; otherwise go to CLR.
- Inference op sequence: LOAD, POS per sample.
  - batch_done pulses after the POS of the last sample of each batch.
  - After the last batch, epoch_done pulses and the block goes to DONE. epochs is ignored.
- Counters:
  - cd_step wraps to 0 at k_dim.
  - sample_idx wraps to 0 at batch_size.
  - batch_idx wraps to 0 at n_batches.
  - epoch_idx increments per epoch.
  - All counters update on the op_done cycle that completes the unit. All are cleared on the start edge.
- Timeout: the counter increments every WAIT cycle. Reaching TIMEOUT without op_done goes to ERR with err_code=2.
- **DONE/ERR:** busy=0, flag set, and the block returns to IDLE on the next cycle. The flags stay sticky.
- soft_rst has priority over everything except ARESET. Whatever the state, including mid-handshake, the next state is IDLE with cmd_valid=0 and done/err/err_code/counters cleared.

## Timing
- Reset values: all outputs 0, state IDLE, start-edge register 0.
- Start edge at cycle t: CHECK at t+1. In train mode accum_clr=1 at t+2 and cmd_valid first at t+3. In inference cmd_valid first at t+2.
- An op_done arriving in ISSUE or IDLE is ignored. An op_done arriving in the same cycle as the handshake is also ignored, so the earliest legal op_done is the first WAIT cycle.
- op_done at cycle u: cmd_valid for the next op at u+1. batch_done/epoch_done pulse at u+1. done rises at u+1 for the final op.
- Updated counters are visible at u+1.
- cmd_op never changes while cmd_valid=1 and cmd_ready=0.
- Changes on configuration inputs after CHECK are don't-care. The sequence uses the values sampled live, so software must keep them stable while busy.

## Test plan
- Train, batch_size=2, n_batches=2, epochs=1, k_dim=1, op_done 3 cycles after each accept -> 18 commands: (LOAD,POS,NEG_V,NEG_H)x2, UPDATE, repeated once more. Expect accum_clr x2, batch_done x2, epoch_done x1, then done=1, busy=0.
- Inference, batch_size=3, n_batches=1 -> LOAD,POS x3, one batch_done, one epoch_done, done=1. accum_clr never pulses and UPDATE is never issued.
- Zero config: train with k_dim=0 -> err=1, err_code=1 two cycles after the start edge, no cmd_valid. Repeat with batch_size=0 in inference -> same result.
- Backpressure: cmd_ready held low for 10 cycles -> cmd_valid and cmd_op stable throughout. A spurious op_done during ISSUE is ignored and the sequence count is unchanged.
- Timeout with TIMEOUT=16 and op_done withheld -> err_code=2 after 16 WAIT cycles. A new start edge clears err and the run restarts at epoch_idx=0.
- Mid-run soft_rst during WAIT of the 5th op -> IDLE next cycle, all flags and counters 0. A start edge while busy (before the soft_rst) produces no restart.
